// File: rtl/bolucu_pkg.sv
// Shared types and constants for the binary32 divider and its operand classifier.
package bolucu_pkg;
  typedef enum logic [1:0] {IDLE, CHECK, DIVIDE, ROUND} durum_e;
  typedef enum logic [1:0] {ZERO, INF, NAN, NORM} sinif_e;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam int          BIAS    = 127;
  localparam int          EXP_MAX = 255;
  localparam int          ITER    = 26;
endpackage

// File: rtl/fp_siniflandir.sv
// Combinational binary32 operand classifier: class, sign, biased exponent and
// 24-bit mantissa with the hidden one. Subnormals classify as ZERO.
module fp_siniflandir
  import bolucu_pkg::*;
(
  input  logic [31:0] sayi_i,
  output sinif_e      sinif_o,
  output logic        isaret_o,
  output logic [7:0]  us_o,
  output logic [23:0] mantis_o
);
  always_comb begin
    isaret_o = sayi_i[31];
    us_o     = sayi_i[30:23];
    mantis_o = {1'b1, sayi_i[22:0]};
    if (sayi_i[30:23] == 8'h00)
      sinif_o = ZERO;
    else if (sayi_i[30:23] == 8'hFF)
      sinif_o = (sayi_i[22:0] != 23'h0) ? NAN : INF;
    else
      sinif_o = NORM;
  end
endmodule

// File: rtl/bolucu.sv
// Sequential binary32 divider: one-cycle special-case resolution, 26-step
// restoring mantissa division, round-to-nearest-even, flush-to-zero.
module bolucu
  import bolucu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        basla,
  input  logic [31:0] sayi1,
  input  logic [31:0] sayi2,
  output logic [31:0] sonuc,
  output logic        bitti,
  output logic        mesgul
);
  localparam logic signed [9:0] US_TAVAN = 10'(EXP_MAX);

  durum_e             durum_q;
  logic [31:0]        a_q, b_q;
  logic               isaret_q;
  logic signed [9:0]  us_q;
  logic [23:0]        ma_q, mb_q;
  logic [25:0]        q_q, r_q;
  logic [4:0]         sayac_q;

  sinif_e             sa, sb;
  logic               ia, ib;
  logic [7:0]         ea, eb;
  logic [23:0]        mta, mtb;

  fp_siniflandir u_sinif_a (.sayi_i(a_q), .sinif_o(sa), .isaret_o(ia), .us_o(ea), .mantis_o(mta));
  fp_siniflandir u_sinif_b (.sayi_i(b_q), .sinif_o(sb), .isaret_o(ib), .us_o(eb), .mantis_o(mtb));

  logic               isaret_d, ozel;
  logic [31:0]        ozel_sonuc;
  logic signed [9:0]  us_d;

  always_comb begin
    isaret_d   = ia ^ ib;
    ozel       = 1'b1;
    ozel_sonuc = '0;
    us_d       = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'(BIAS);
    if (sa == NAN || sb == NAN || (sa == ZERO && sb == ZERO) || (sa == INF && sb == INF))
      ozel_sonuc = QNAN;
    else if (sa == INF || sb == ZERO)
      ozel_sonuc = {isaret_d, 8'hFF, 23'h0};
    else if (sa == ZERO || sb == INF)
      ozel_sonuc = {isaret_d, 31'h0};
    else
      ozel = 1'b0;
  end

  // The dividend (ma << 25) never yields quotient bits above 25, so the first
  // step compares ma directly instead of shifting in 25 leading dividend bits.
  logic [25:0] r_cur, fark, r_next;
  logic        qbit;

  always_comb begin
    r_cur  = (sayac_q == '0) ? {2'b00, ma_q} : r_q;
    fark   = r_cur - {2'b00, mb_q};
    qbit   = (r_cur >= {2'b00, mb_q});
    r_next = (qbit ? fark : r_cur) << 1;
  end

  logic [23:0]       mant;
  logic              guard, sticky, inc;
  logic [24:0]       toplam;
  logic [22:0]       kesir;
  logic signed [9:0] us_r, us_f;
  logic [31:0]       yuvarla;

  always_comb begin
    if (q_q[25]) begin
      mant   = q_q[25:2];
      guard  = q_q[1];
      sticky = q_q[0] | (r_q != '0);
      us_r   = us_q;
    end else begin
      mant   = q_q[24:1];
      guard  = q_q[0];
      sticky = (r_q != '0);
      us_r   = us_q - 10'sd1;
    end
    inc    = guard & (sticky | mant[0]);
    toplam = {1'b0, mant} + {24'b0, inc};
    kesir  = toplam[24] ? toplam[23:1] : toplam[22:0];
    us_f   = us_r + $signed({9'b0, toplam[24]});
    if (us_f >= US_TAVAN)
      yuvarla = {isaret_q, 8'hFF, 23'h0};
    else if (us_f <= 10'sd0)
      yuvarla = {isaret_q, 31'h0};
    else
      yuvarla = {isaret_q, us_f[7:0], kesir};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      durum_q  <= IDLE;
      sonuc    <= '0;
      bitti    <= 1'b0;
      mesgul   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      isaret_q <= 1'b0;
      us_q     <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      q_q      <= '0;
      r_q      <= '0;
      sayac_q  <= '0;
    end else begin
      case (durum_q)
        IDLE: begin
          bitti  <= 1'b0;
          mesgul <= 1'b0;
          if (!bitti && basla) begin
            a_q     <= sayi1;
            b_q     <= sayi2;
            mesgul  <= 1'b1;
            durum_q <= CHECK;
          end
        end
        CHECK: begin
          isaret_q <= isaret_d;
          if (ozel) begin
            sonuc   <= ozel_sonuc;
            bitti   <= 1'b1;
            durum_q <= IDLE;
          end else begin
            ma_q    <= mta;
            mb_q    <= mtb;
            us_q    <= us_d;
            q_q     <= '0;
            r_q     <= '0;
            sayac_q <= '0;
            durum_q <= DIVIDE;
          end
        end
        DIVIDE: begin
          q_q     <= {q_q[24:0], qbit};
          r_q     <= r_next;
          sayac_q <= sayac_q + 5'd1;
          if (sayac_q == 5'(ITER - 1))
            durum_q <= ROUND;
        end
        ROUND: begin
          sonuc   <= yuvarla;
          bitti   <= 1'b1;
          durum_q <= IDLE;
        end
        default: durum_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bolucu.sv
// Directed self-checking bench for the bolucu binary32 divider.
module tb_bolucu;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        basla = 1'b0;
  logic [31:0] sayi1 = '0;
  logic [31:0] sayi2 = '0;
  logic [31:0] sonuc;
  logic        bitti;
  logic        mesgul;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bolucu dut (
    .clk   (clk),
    .reset (reset),
    .basla (basla),
    .sayi1 (sayi1),
    .sayi2 (sayi2),
    .sonuc (sonuc),
    .bitti (bitti),
    .mesgul(mesgul)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] bek);
    checks++;
    assert (obs === bek) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, bek);
    end
  endtask

  // Launch one division; optionally re-pulse basla 'ikinci' cycles after acceptance.
  task automatic bol(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] bek, input int gecikme, input int ikinci);
    int   n;
    logic dustu;
    @(negedge clk);
    sayi1 = a;
    sayi2 = b;
    basla = 1'b1;
    @(posedge clk); #1;
    basla = 1'b0;
    sayi1 = 32'hDEADBEEF;
    sayi2 = 32'h40000000;
    n     = 0;
    dustu = (mesgul !== 1'b1);
    while (bitti !== 1'b1 && n < 60) begin
      basla = (ikinci != 0 && n == ikinci);
      @(posedge clk); #1;
      n++;
      if (mesgul !== 1'b1) dustu = 1'b1;
    end
    basla = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'(gecikme));
    chk({tag, "_sonuc"}, sonuc, bek);
    chk({tag, "_mesgul_low_early"}, {31'b0, dustu}, 32'h0);
    @(posedge clk); #1;
    chk({tag, "_bitti_mesgul_after"}, {30'b0, bitti, mesgul}, 32'h0);
  endtask

  initial begin
    #12;
    chk("reset_sonuc", sonuc, 32'h0);
    chk("reset_flags", {30'b0, bitti, mesgul}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    bol("div_6_2",    32'h40C00000, 32'h40000000, 32'h40400000, 28, 0);
    bol("div_1_3",    32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28, 0);
    bol("div_m1_3",   32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 28, 0);

    bol("nan_op",     32'h7FC00000, 32'hC12AAAAA, 32'h7FC00000, 1, 0);
    bol("ninf_norm",  32'hFF800000, 32'h412AAAAA, 32'hFF800000, 1, 0);
    bol("inf_inf",    32'h7F800000, 32'h7F800000, 32'h7FC00000, 1, 0);
    bol("zero_zero",  32'h00000000, 32'h00000000, 32'h7FC00000, 1, 0);
    bol("one_nzero",  32'h3F800000, 32'h80000000, 32'hFF800000, 1, 0);
    bol("zero_norm",  32'h00000000, 32'h412AAAAA, 32'h00000000, 1, 0);

    bol("underflow",  32'h00800000, 32'h40000000, 32'h00000000, 28, 0);
    bol("subnormal",  32'h00000001, 32'h3F800000, 32'h00000000, 1, 0);
    bol("ignored_basla", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28, 5);
    bol("overflow",   32'h7F7FFFFF, 32'h3E800000, 32'h7F800000, 28, 0);

    // Abort mid-division: CHECK at edge 1, iteration 10 completes at edge 11.
    @(negedge clk);
    sayi1 = 32'h40C00000;
    sayi2 = 32'h40000000;
    basla = 1'b1;
    @(posedge clk); #1;
    basla = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_sonuc", sonuc, 32'h0);
    chk("abort_flags", {30'b0, bitti, mesgul}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_held", {30'b0, bitti, mesgul}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("release_idle", {30'b0, bitti, mesgul}, 32'h0);

    bol("after_reset", 32'h40C00000, 32'h40000000, 32'h40400000, 28, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bolucu.md
# bolucu

Sequential IEEE-754 single-precision divider, the counterpart of the `carpici` multiplier in the floating-point datapath. It computes `sayi1 / sayi2` with a radix-2 restoring mantissa divider and rounds to nearest-even. Special operands are resolved in one cycle. Results are flushed to zero when subnormal. A start/done handshake lets the surrounding datapath or bench launch one division at a time and collect `sonuc` when it is ready.

## Interface
- No parameters; format is fixed binary32.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `basla`  in  1  start request; sampled only in IDLE.
- `sayi1`  in  32  dividend, binary32.
- `sayi2`  in  32  divisor, binary32.
- `sonuc`  out  32  quotient, binary32; held until the next result.
- `bitti`  out  1  one-cycle pulse: `sonuc` updated this cycle.
- `mesgul`  out  1  high from the cycle after `basla` is accepted until the `bitti` cycle, inclusive.

## Operation
- **Reset values.** While `reset`=0: `sonuc`=0, `bitti`=0, `mesgul`=0, state=IDLE, all internal registers cleared.
- **IDLE.** When `basla`=1, latch `sayi1` and `sayi2`, then go to CHECK. When not in IDLE, `basla` is ignored; no queueing.
- **CHECK.** Classify each operand as ZERO (exp=0, any fraction; subnormals are treated as zero), INF, NAN or NORM. Result sign is `s1^s2`.
  - Either operand NAN, 0/0, or inf/inf → `7FC00000` (canonical qNaN, sign 0).
  - INF/(NORM or ZERO) or NORM/ZERO → signed infinity.
  - ZERO/(NORM or INF) or NORM/INF → signed zero.
  - Any special case: write `sonuc`, pulse `bitti`, return to IDLE.
  - NORM/NORM: build mantissas `ma`, `mb` (24 bits, hidden 1), exponent `e = ea − eb + 127` as a 10-bit signed value, clear the partial remainder, go to DIVIDE.
- **DIVIDE.** 26 iterations, one quotient bit per clock. This computes `q = floor((ma << 25) / mb)`, with q in [2^24, 2^26), plus the final remainder `r`.
- **ROUND.**
  - If `q[25]`=1: mantissa = `q[25:2]`, guard = `q[1]`, sticky = `q[0] | (r≠0)`, exponent = `e`.
  - Otherwise: mantissa = `q[24:1]`, guard = `q[0]`, sticky = `(r≠0)`, exponent = `e − 1`.
  - Round to nearest-even: increment when `guard & (sticky | lsb)`.
  - A rounding carry out of the mantissa (`FFFFFF` + 1) yields mantissa `800000` and exponent + 1.
  - Final exponent ≥ 255 → signed infinity. Final exponent ≤ 0 → signed zero (flush, no subnormal output).
  - Write `sonuc`, pulse `bitti`, go to IDLE.

## Timing
- Edge 0 samples `basla`; `mesgul` is high after edge 0.
- **Special path:** `sonuc`/`bitti` are updated at edge 1. Latency is 1 cycle.
- **Normal path:** CHECK at edge 1, DIVIDE at edges 2–27, ROUND at edge 28. `sonuc`/`bitti` are updated at edge 28. Latency is 28 cycles.
- `bitti` is high for exactly one cycle. `mesgul` falls at the edge after `bitti`.
- A new `basla` is accepted in the cycle where `bitti`=0 and the state is IDLE, i.e. at the earliest on the edge after `bitti`.
- `sayi1`/`sayi2` may change freely after edge 0; the latched copies are used.
- Reset asserted mid-operation aborts immediately, asynchronously, with no partial `bitti`. After release the block is idle and the old operands are discarded.

## Structure
- Package `bolucu_pkg` holds:
  - state enum IDLE, CHECK, DIVIDE, ROUND;
  - class enum ZERO, INF, NAN, NORM;
  - constants `QNAN=32'h7FC00000`, `BIAS=127`, `EXP_MAX=255`, `ITER=26`.
- Sub-module `fp_siniflandir` (combinational, instantiated twice) maps a 32-bit operand to class, sign, exponent and 24-bit mantissa. It is reusable by `carpici`.

## Test plan
- 6.0 / 2.0 (`40C00000` / `40000000`) → `40400000`. `bitti` arrives 28 cycles after `basla`. `mesgul` is high from edge 0 through the `bitti` cycle.
- 1.0 / 3.0 (`3F800000` / `40400000`) → `3EAAAAAB`, which checks RNE round-up. −1.0 / 3.0 (`BF800000` / `40400000`) → `BEAAAAAB`.
- Specials, each with `bitti` after 1 cycle:
  - `7FC00000` / `C12AAAAA` → `7FC00000`
  - `FF800000` / `412AAAAA` → `FF800000`
  - `7F800000` / `7F800000` → `7FC00000`
  - `00000000` / `00000000` → `7FC00000`
  - `3F800000` / `80000000` → `FF800000`
  - `00000000` / `412AAAAA` → `00000000`
- Range limits:
  - Overflow: `7F7FFFFF` / `3E800000` → `7F800000`.
  - Underflow: `00800000` / `40000000` → `00000000`.
  - Subnormal operand: `00000001` / `3F800000` → `00000000`.
- Handshake and reset:
  - `basla` pulsed again during DIVIDE is ignored; the result matches the first operands.
  - `reset`=0 at DIVIDE iteration 10 immediately gives `sonuc`=0, `bitti`=0, `mesgul`=0.
  - After release, 6.0 / 2.0 gives `40400000` with normal latency.
